// File: rtl/stopwatch_controller_pkg.sv
// Shared types and constants for the stopwatch controller.
// Holds the FSM state encoding and the BCD digit limit.
package stopwatch_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } sw_state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/stopwatch_controller_bcd_counter_99.sv
// Two-digit BCD counter 00..99.
// Wraps to 00 at 99, or holds at 99 when wrap_stop is set.
module bcd_counter_99
    import stopwatch_controller_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic       wrap_stop,
    output logic [3:0] count_high,
    output logic [3:0] count_low,
    output logic       at_max
);

    logic [3:0] high_q, high_d;
    logic [3:0] low_q, low_d;

    assign at_max     = (high_q == BCD_MAX) && (low_q == BCD_MAX);
    assign count_high = high_q;
    assign count_low  = low_q;

    // next count: clear wins, then a single BCD step on enable
    always_comb begin
        high_d = high_q;
        low_d  = low_q;
        if (clear) begin
            high_d = 4'd0;
            low_d  = 4'd0;
        end else if (enable) begin
            if (at_max) begin
                if (!wrap_stop) begin
                    high_d = 4'd0;
                    low_d  = 4'd0;
                end
            end else if (low_q == BCD_MAX) begin
                low_d  = 4'd0;
                high_d = high_q + 4'd1;
            end else begin
                low_d = low_q + 4'd1;
            end
        end
    end

    // digit registers
    always_ff @(posedge clock) begin
        if (reset) begin
            high_q <= 4'd0;
            low_q  <= 4'd0;
        end else begin
            high_q <= high_d;
            low_q  <= low_d;
        end
    end

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch sequencer: button edge detect, prescaler and FSM
// around a BCD 00..99 counter, with a lap snapshot display.
module stopwatch_controller
    import stopwatch_controller_pkg::*;
#(
    parameter int PRESCALE   = 4,
    parameter bit STOP_AT_99 = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_pause,
    input  logic       lap,
    input  logic       clear,
    output logic [3:0] disp_high,
    output logic [3:0] disp_low,
    output logic       running,
    output logic       lap_active,
    output logic       wrap,
    output logic       done
);

    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    // buttons ordered {clear, lap, start}
    logic [2:0] btn_q, prev_q, press;
    logic       start_p, lap_p, clr_p;

    sw_state_e     state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [7:0]    snap_q, snap_d;
    logic          lap_q, lap_d;
    logic          wrap_d;
    logic [7:0]    disp_q;
    logic          running_q, done_q, wrap_q;

    logic       tick, cnt_en, at_max;
    logic [3:0] cnt_high, cnt_low;

    assign press   = btn_q & ~prev_q;
    assign start_p = press[0];
    assign lap_p   = press[1];
    assign clr_p   = press[2];

    assign tick   = (state_q == ST_RUN) && (pre_q == PRE_LAST);
    assign cnt_en = tick && !clr_p;

    bcd_counter_99 u_cnt (
        .clock      (clock),
        .reset      (reset),
        .clear      (clr_p),
        .enable     (cnt_en),
        .wrap_stop  (STOP_AT_99),
        .count_high (cnt_high),
        .count_low  (cnt_low),
        .at_max     (at_max)
    );

    // sample buttons, then delay once more for rising-edge detect
    always_ff @(posedge clock) begin
        if (reset) begin
            btn_q  <= 3'b000;
            prev_q <= 3'b000;
        end else begin
            btn_q  <= {clear, lap, start_pause};
            prev_q <= btn_q;
        end
    end

    // FSM next state; clear overrides every other press
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        snap_d  = snap_q;
        lap_d   = lap_q;
        wrap_d  = 1'b0;
        if (clr_p) begin
            state_d = ST_IDLE;
            pre_d   = '0;
            lap_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_p) state_d = ST_RUN;
                end
                ST_RUN: begin
                    pre_d = tick ? '0 : pre_q + 1'b1;
                    if (lap_p) begin
                        snap_d = {cnt_high, cnt_low};
                        lap_d  = 1'b1;
                    end
                    if (start_p) state_d = ST_PAUSE;
                    if (tick && at_max) begin
                        if (STOP_AT_99) state_d = ST_DONE;
                        else            wrap_d  = 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (lap_p)   lap_d   = 1'b0;
                    if (start_p) state_d = ST_RUN;
                end
                ST_DONE: begin
                end
            endcase
        end
    end

    // FSM state and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pre_q     <= '0;
            snap_q    <= 8'h00;
            lap_q     <= 1'b0;
            disp_q    <= 8'h00;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            snap_q    <= snap_d;
            lap_q     <= lap_d;
            disp_q    <= lap_q ? snap_q : {cnt_high, cnt_low};
            running_q <= (state_d == ST_RUN);
            done_q    <= (state_d == ST_DONE);
            wrap_q    <= wrap_d;
        end
    end

    assign disp_high  = disp_q[7:4];
    assign disp_low   = disp_q[3:0];
    assign running    = running_q;
    assign lap_active = lap_q;
    assign wrap       = wrap_q;
    assign done       = done_q;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Bench for stopwatch_controller: wrap and stop-at-99 builds
// driven together and compared every cycle with a count model.
module tb_stopwatch_controller;

    localparam int P = 4;

    logic clock = 1'b0;
    logic reset, start_pause, lap, clear;
    logic [3:0] dh0, dl0, dh1, dl1;
    logic [1:0] run_o, lap_o, wrap_o, done_o;

    int total = 0;
    int bad   = 0;

    // model state, index 0 = wrapping build, 1 = stop-at-99 build
    int m_cnt[2], m_pre[2], m_snap[2], m_disp[2];
    bit m_run[2], m_pau[2], m_done[2], m_lap[2], m_wrap[2];
    bit h1s, h1l, h1c, h2s, h2l, h2c;

    stopwatch_controller #(.PRESCALE(P), .STOP_AT_99(1'b0)) dut0 (
        .clock       (clock),
        .reset       (reset),
        .start_pause (start_pause),
        .lap         (lap),
        .clear       (clear),
        .disp_high   (dh0),
        .disp_low    (dl0),
        .running     (run_o[0]),
        .lap_active  (lap_o[0]),
        .wrap        (wrap_o[0]),
        .done        (done_o[0])
    );

    stopwatch_controller #(.PRESCALE(P), .STOP_AT_99(1'b1)) dut1 (
        .clock       (clock),
        .reset       (reset),
        .start_pause (start_pause),
        .lap         (lap),
        .clear       (clear),
        .disp_high   (dh1),
        .disp_low    (dl1),
        .running     (run_o[1]),
        .lap_active  (lap_o[1]),
        .wrap        (wrap_o[1]),
        .done        (done_o[1])
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0d want=%0d", tag, obs, exp);
        end
    endtask

    // one rising edge of the reference behaviour
    task automatic model_edge();
        bit sp, lp, cp, tick;
        sp = h1s & ~h2s;
        lp = h1l & ~h2l;
        cp = h1c & ~h2c;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_cnt[k] = 0; m_pre[k] = 0; m_snap[k] = 0;
                m_disp[k] = 0; m_run[k] = 0; m_pau[k] = 0;
                m_done[k] = 0; m_lap[k] = 0; m_wrap[k] = 0;
            end else begin
                m_disp[k] = m_lap[k] ? m_snap[k] : m_cnt[k];
                m_wrap[k] = 0;
                if (cp) begin
                    m_run[k] = 0; m_pau[k] = 0; m_done[k] = 0;
                    m_cnt[k] = 0; m_pre[k] = 0; m_lap[k] = 0;
                end else if (m_run[k]) begin
                    tick = (m_pre[k] == P - 1);
                    m_pre[k] = tick ? 0 : m_pre[k] + 1;
                    if (lp) begin
                        m_snap[k] = m_cnt[k];
                        m_lap[k] = 1;
                    end
                    if (sp) begin
                        m_run[k] = 0; m_pau[k] = 1;
                    end
                    if (tick) begin
                        if (m_cnt[k] == 99) begin
                            if (k == 1) begin
                                m_done[k] = 1; m_run[k] = 0; m_pau[k] = 0;
                            end else begin
                                m_cnt[k] = 0; m_wrap[k] = 1;
                            end
                        end else begin
                            m_cnt[k] = m_cnt[k] + 1;
                        end
                    end
                end else if (m_pau[k]) begin
                    if (lp) m_lap[k] = 0;
                    if (sp) begin
                        m_pau[k] = 0; m_run[k] = 1;
                    end
                end else if (!m_done[k]) begin
                    if (sp) m_run[k] = 1;
                end
            end
        end
        if (reset) begin
            {h1s, h1l, h1c, h2s, h2l, h2c} = '0;
        end else begin
            h2s = h1s; h2l = h1l; h2c = h1c;
            h1s = start_pause; h1l = lap; h1c = clear;
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        model_edge();
        #1;
        chk("disp_hi0", dh0, m_disp[0] / 10);
        chk("disp_lo0", dl0, m_disp[0] % 10);
        chk("running0", run_o[0], m_run[0]);
        chk("lap0", lap_o[0], m_lap[0]);
        chk("wrap0", wrap_o[0], m_wrap[0]);
        chk("done0", done_o[0], m_done[0]);
        chk("disp_hi1", dh1, m_disp[1] / 10);
        chk("disp_lo1", dl1, m_disp[1] % 10);
        chk("running1", run_o[1], m_run[1]);
        chk("lap1", lap_o[1], m_lap[1]);
        chk("wrap1", wrap_o[1], m_wrap[1]);
        chk("done1", done_o[1], m_done[1]);
    endtask

    task automatic press_start();
        start_pause = 1'b1; cyc(); start_pause = 1'b0; cyc();
    endtask

    task automatic press_lap();
        lap = 1'b1; cyc(); lap = 1'b0; cyc();
    endtask

    task automatic run_to(input int v);
        int n;
        n = 0;
        while (m_cnt[0] != v && n < 2000) begin
            cyc();
            n++;
        end
        if (n >= 2000) chk("run_to_timeout", m_cnt[0], v);
    endtask

    initial begin
        int wraps;
        reset = 1'b1; start_pause = 1'b0; lap = 1'b0; clear = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
        cyc();
        chk("rst_disp", {dh0, dl0}, 8'h00);
        chk("rst_run", run_o[0], 1'b0);

        // held start: single press, running two edges later
        start_pause = 1'b1;
        cyc();
        chk("run_early", run_o[0], 1'b0);
        cyc();
        chk("run_2edge", run_o[0], 1'b1);
        repeat (8) cyc();
        start_pause = 1'b0;
        chk("held_one_press", run_o[0], 1'b1);

        // pause at 07 and resume mid-prescale
        run_to(7);
        press_start();
        repeat (20) cyc();
        chk("pause07", {dh0, dl0}, 8'h07);
        press_start();

        // lap freeze, recapture, release in pause
        run_to(23);
        press_lap();
        run_to(28);
        chk("lap_frozen23", {dh0, dl0}, 8'h23);
        run_to(30);
        press_lap();
        cyc();
        chk("lap30", {dh0, dl0}, 8'h30);
        press_start();
        press_lap();
        cyc();
        chk("lap_off_pause", lap_o[0], 1'b0);
        press_start();

        // clear and start together at 45
        run_to(45);
        start_pause = 1'b1; clear = 1'b1;
        cyc();
        start_pause = 1'b0; clear = 1'b0;
        cyc(); cyc();
        chk("clr_disp", {dh0, dl0}, 8'h00);
        chk("clr_run", run_o[0], 1'b0);
        chk("clr_lap", lap_o[0], 1'b0);

        // reset mid-run at 62 with lap held
        press_start();
        run_to(62);
        press_lap();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("mrst_disp", {dh0, dl0}, 8'h00);
        chk("mrst_lap", lap_o[0], 1'b0);
        chk("mrst_run", run_o[0], 1'b0);
        press_start();
        repeat (P + 2) cyc();
        chk("restart_01", {dh0, dl0}, 8'h01);

        // rollover versus stop at 99
        run_to(98);
        wraps = 0;
        for (int i = 0; i < 3 * P; i++) begin
            cyc();
            if (wrap_o[0] === 1'b1) wraps++;
        end
        chk("wrap_once", wraps, 1);
        chk("done_stop", done_o[1], 1'b1);
        chk("hold99", {dh1, dl1}, 8'h99);
        press_start();
        press_lap();
        repeat (10) cyc();
        chk("done_ignore", done_o[1], 1'b1);
        chk("hold99b", {dh1, dl1}, 8'h99);

        // random button traffic
        clear = 1'b1; cyc(); clear = 1'b0; cyc();
        for (int i = 0; i < 3000; i++) begin
            start_pause = ($urandom_range(0, 5) == 0);
            lap         = ($urandom_range(0, 7) == 0);
            clear       = ($urandom_range(0, 60) == 0);
            reset       = ($urandom_range(0, 400) == 0);
            cyc();
        end
        reset = 1'b0; start_pause = 1'b0; lap = 1'b0; clear = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
